// File: rtl/kfmmc_write_sequencer.sv
// Multi-block write front end for the KFMMC drive byte-register interface.
// Buffers the write byte stream in a small FIFO and sequences address, command and data strobes.
module kfmmc_write_sequencer #(
  parameter int         FIFO_DEPTH    = 16,
  parameter logic [7:0] WRITE_COMMAND = 8'h81
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_block,
  input  logic [7:0]  cmd_count,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [7:0]  internal_data_bus,
  output logic        write_block_address_1,
  output logic        write_block_address_2,
  output logic        write_block_address_3,
  output logic        write_block_address_4,
  output logic        write_access_command,
  output logic        write_data,
  output logic        read_data,
  input  logic        drive_busy,
  input  logic        request_write_data_interrupt,
  input  logic        write_completion_interrupt,
  input  logic        write_interface_error,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [8:0]  blocks_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [3:0] {
    IDLE, WAIT_READY, ADDR1, ADDR2, ADDR3, ADDR4, START,
    WAIT_INT, SEND_DATA, READ_RESULT, NEXT, FINISH
  } state_t;

  state_t      state;
  logic [31:0] blk;
  logic [7:0]  remaining;
  logic [7:0]  byte_reg;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fcount;
  logic          fifo_empty, push, pop, flush;
  logic [7:0]    head;

  assign busy       = (state != IDLE);
  assign cmd_ready  = (state == IDLE);
  assign s_ready    = busy && (fcount != FULL);
  assign fifo_empty = (fcount == '0);
  assign head       = mem[rd_ptr];
  assign push       = s_valid && s_ready;
  assign pop        = (state == WAIT_INT) && !write_completion_interrupt &&
                      request_write_data_interrupt && !fifo_empty;
  // An aborted command must not leak its leftover bytes into the next one.
  assign flush      = (state == READ_RESULT) && error;

  always_ff @(posedge clock)
    if (push) mem[wr_ptr] <= s_data;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fcount <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (flush) begin
        rd_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
        fcount <= '0;
      end else begin
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   fcount <= fcount + 1'b1;
          2'b01:   fcount <= fcount - 1'b1;
          default: fcount <= fcount;
        endcase
      end
    end
  end

  // Outputs are registered: each transition loads the strobes of the state being entered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state                 <= IDLE;
      blk                   <= '0;
      remaining             <= '0;
      byte_reg              <= '0;
      internal_data_bus     <= '0;
      write_block_address_1 <= 1'b0;
      write_block_address_2 <= 1'b0;
      write_block_address_3 <= 1'b0;
      write_block_address_4 <= 1'b0;
      write_access_command  <= 1'b0;
      write_data            <= 1'b0;
      read_data             <= 1'b0;
      done                  <= 1'b0;
      error                 <= 1'b0;
      blocks_done           <= '0;
    end else begin
      internal_data_bus     <= '0;
      write_block_address_1 <= 1'b0;
      write_block_address_2 <= 1'b0;
      write_block_address_3 <= 1'b0;
      write_block_address_4 <= 1'b0;
      write_access_command  <= 1'b0;
      write_data            <= 1'b0;
      read_data             <= 1'b0;
      done                  <= 1'b0;
      case (state)
        IDLE: if (cmd_valid) begin
          blk         <= cmd_block;
          remaining   <= cmd_count;
          error       <= 1'b0;
          blocks_done <= '0;
          if (cmd_count == 8'd0) begin
            state <= FINISH;
            done  <= 1'b1;
          end else begin
            state <= WAIT_READY;
          end
        end
        WAIT_READY: if (!drive_busy) begin
          state                 <= ADDR1;
          write_block_address_1 <= 1'b1;
          internal_data_bus     <= blk[7:0];
        end
        ADDR1: begin
          state                 <= ADDR2;
          write_block_address_2 <= 1'b1;
          internal_data_bus     <= blk[15:8];
        end
        ADDR2: begin
          state                 <= ADDR3;
          write_block_address_3 <= 1'b1;
          internal_data_bus     <= blk[23:16];
        end
        ADDR3: begin
          state                 <= ADDR4;
          write_block_address_4 <= 1'b1;
          internal_data_bus     <= blk[31:24];
        end
        ADDR4: begin
          state                <= START;
          write_access_command <= 1'b1;
          internal_data_bus    <= WRITE_COMMAND;
        end
        START: state <= WAIT_INT;
        WAIT_INT: begin
          if (write_completion_interrupt) begin
            error     <= write_interface_error;
            read_data <= 1'b1;
            state     <= READ_RESULT;
          end else if (pop) begin
            byte_reg          <= head;
            internal_data_bus <= head;
            write_data        <= 1'b1;
            state             <= SEND_DATA;
          end
        end
        SEND_DATA: begin
          if (request_write_data_interrupt) begin
            write_data        <= 1'b1;
            internal_data_bus <= byte_reg;
          end else begin
            state <= WAIT_INT;
          end
        end
        READ_RESULT: begin
          if (error) begin
            state <= FINISH;
            done  <= 1'b1;
          end else begin
            blocks_done <= blocks_done + 9'd1;
            state       <= NEXT;
          end
        end
        NEXT: begin
          blk       <= blk + 32'd1;
          remaining <= remaining - 8'd1;
          if (remaining != 8'd1) begin
            state <= WAIT_READY;
          end else begin
            state <= FINISH;
            done  <= 1'b1;
          end
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
